// File: rtl/clock_pkg.sv
// Shared definitions for the clock load scheduler.
//   state_t : load-sequencer FSM encoding
//   SEC_MAX / MIN_MAX : largest legal second / minute values
package clock_pkg;

  typedef enum logic [2:0] {
    ARM     = 3'd0,
    IDLE    = 3'd1,
    CHECK   = 3'd2,
    LD_SEC  = 3'd3,
    LD_MIN  = 3'd4,
    LD_HOUR = 3'd5,
    RUN     = 3'd6
  } state_t;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

endpackage

// File: rtl/time_range_chk.sv
// Combinational range check of a requested time.
//   hour, min, sec : candidate time fields (6 bits each)
//   bad            : 1 when any field exceeds its legal maximum
module time_range_chk
  import clock_pkg::*;
#(
  parameter int HOUR_MAX = 23
) (
  input  logic [5:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  output logic       bad
);

  localparam logic [5:0] H_LIM = 6'(HOUR_MAX);
  localparam logic [5:0] M_LIM = 6'(MIN_MAX);
  localparam logic [5:0] S_LIM = 6'(SEC_MAX);

  assign bad = (hour > H_LIM) || (min > M_LIM) || (sec > S_LIM);

endmodule

// File: rtl/clock_load_sched.sv
// Load scheduler for a seconds/minutes/hours counter chain.
// Accepts a set-time request, range checks it, then loads seconds, minutes
// and hours on three consecutive cycles before letting the tick through.
//   clk, rst                    : clock, async active-low reset
//   tick_in                     : 1 Hz single-cycle pulse
//   set_req, set_hour/min/sec   : request handshake + requested time
//   set_ack, set_err            : completion pulse, reject flag
//   sec_in/min_in/hour_in       : load values (the holding registers)
//   sec_load/min_load/hour_load : single-cycle load strobes
//   cnt_en                      : tick gated to RUN
//   running                     : high in RUN
//   missed                      : saturating count of dropped ticks
module clock_load_sched
  import clock_pkg::*;
#(
  parameter int HOUR_MAX   = 23,
  parameter int ARM_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       set_req,
  input  logic [5:0] set_hour,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  output logic       set_ack,
  output logic       set_err,
  output logic [5:0] sec_in,
  output logic [5:0] min_in,
  output logic [5:0] hour_in,
  output logic       sec_load,
  output logic       min_load,
  output logic       hour_load,
  output logic       cnt_en,
  output logic       running,
  output logic [3:0] missed
);

  localparam int            AW       = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYCLES - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] arm_cnt;
  logic [5:0]    hold_h, hold_m, hold_s;
  logic          from_run;
  logic          bad;
  logic          accept;

  time_range_chk #(.HOUR_MAX(HOUR_MAX)) u_chk (
    .hour (hold_h),
    .min  (hold_m),
    .sec  (hold_s),
    .bad  (bad)
  );

  // The ack cycle is ignored so a requester that drops set_req on seeing
  // set_ack is not taken as a second request; a held request is captured
  // on the following cycle.
  assign accept = set_req && !set_ack && ((state == IDLE) || (state == RUN));

  always_comb begin
    state_nxt = state;
    case (state)
      ARM:     if (arm_cnt == ARM_LAST) state_nxt = IDLE;
      IDLE:    if (accept) state_nxt = CHECK;
      RUN:     if (accept) state_nxt = CHECK;
      CHECK:   state_nxt = bad ? (from_run ? RUN : IDLE) : LD_SEC;
      LD_SEC:  state_nxt = LD_MIN;
      LD_MIN:  state_nxt = LD_HOUR;
      LD_HOUR: state_nxt = RUN;
      default: state_nxt = ARM;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARM;
      arm_cnt  <= '0;
      hold_h   <= '0;
      hold_m   <= '0;
      hold_s   <= '0;
      from_run <= 1'b0;
      set_ack  <= 1'b0;
      set_err  <= 1'b0;
      missed   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARM) arm_cnt <= arm_cnt + 1'b1;
      if (accept) begin
        hold_h   <= set_hour;
        hold_m   <= set_min;
        hold_s   <= set_sec;
        from_run <= (state == RUN);
      end
      // Ack is registered, so it shows in the cycle after CHECK (reject)
      // or after LD_HOUR (accept): N+5 for a request seen at edge N.
      set_ack <= ((state == CHECK) && bad) || (state == LD_HOUR);
      set_err <= (state == CHECK) && bad;
      // The tick dropped during LD_HOUR is still counted so the full loss
      // of the load window is visible alongside set_ack; the count is
      // cleared at the end of that ack cycle (state is RUN, so nothing
      // else can increment it then).
      if (set_ack && !set_err)
        missed <= '0;
      else if (tick_in && (state != RUN) && (state != ARM) && (missed != 4'hF))
        missed <= missed + 4'd1;
    end
  end

  assign sec_in    = hold_s;
  assign min_in    = hold_m;
  assign hour_in   = hold_h;
  assign sec_load  = (state == LD_SEC);
  assign min_load  = (state == LD_MIN);
  assign hour_load = (state == LD_HOUR);
  assign running   = (state == RUN);
  assign cnt_en    = tick_in && (state == RUN);

endmodule

// File: tb/tb_clock_load_sched.sv
module tb_clock_load_sched;
  import clock_pkg::*;

  logic       clk, rst, tick_in, set_req;
  logic [5:0] set_hour, set_min, set_sec;
  logic       set_ack, set_err, sec_load, min_load, hour_load, cnt_en, running;
  logic [5:0] sec_in, min_in, hour_in;
  logic [3:0] missed;

  int n_checks = 0;
  int n_fail   = 0;

  clock_load_sched dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .set_req(set_req),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .set_ack(set_ack), .set_err(set_err),
    .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
    .sec_load(sec_load), .min_load(min_load), .hour_load(hour_load),
    .cnt_en(cnt_en), .running(running), .missed(missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are examined 1 time unit after the falling edge, inputs are
  // changed right after that, well clear of the rising edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; tick_in = 1'b0; set_req = 1'b0;
    set_hour = 6'd0; set_min = 6'd0; set_sec = 6'd0;
    #3;
    n_checks++;
    if ({set_ack, set_err, sec_load, min_load, hour_load, cnt_en, running, missed,
         sec_in, min_in, hour_in} !== 29'd0) begin
      n_fail++; $display("FAIL reset_outputs: got ack=%b err=%b ld=%b%b%b en=%b run=%b missed=%0d want all 0",
                         set_ack, set_err, sec_load, min_load, hour_load, cnt_en, running, missed);
    end
    step();
    rst = 1'b1; tick_in = 1'b1;
    #1;
    n_checks++;
    if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL arm_cnt_en_c0: got %b want 0", cnt_en); end
    step();
    n_checks++;
    if (cnt_en !== 1'b0 || dut.state !== ARM) begin
      n_fail++; $display("FAIL arm_c1: got cnt_en=%b state=%0d want 0/ARM", cnt_en, dut.state);
    end
    step();
    n_checks++;
    if (dut.state !== IDLE || running !== 1'b0 || cnt_en !== 1'b0 || missed !== 4'd0) begin
      n_fail++; $display("FAIL arm_to_idle: got state=%0d run=%b en=%b missed=%0d want IDLE/0/0/0",
                         dut.state, running, cnt_en, missed);
    end
    step();
    n_checks++;
    if (missed !== 4'd1) begin n_fail++; $display("FAIL idle_missed: got %0d want 1", missed); end
    tick_in = 1'b0;
  endtask

  task automatic test_saturate();
    tick_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 4) begin
        n_checks++;
        if (missed !== 4'd6) begin n_fail++; $display("FAIL missed_count: got %0d want 6", missed); end
      end
    end
    tick_in = 1'b0;
    n_checks++;
    if (missed !== 4'd15) begin n_fail++; $display("FAIL missed_sat: got %0d want 15", missed); end
  endtask

  task automatic test_load();
    set_req = 1'b1; set_hour = 6'd12; set_min = 6'd34; set_sec = 6'd56;
    step();
    n_checks++;
    if (running !== 1'b0 || {sec_load, min_load, hour_load} !== 3'b000 || set_ack !== 1'b0) begin
      n_fail++; $display("FAIL load_check: got run=%b ld=%b%b%b ack=%b want 0/000/0",
                         running, sec_load, min_load, hour_load, set_ack);
    end
    step();
    n_checks++;
    if ({sec_load, min_load, hour_load} !== 3'b100 || sec_in !== 6'd56) begin
      n_fail++; $display("FAIL load_sec: got ld=%b%b%b sec_in=%0d want 100/56", sec_load, min_load, hour_load, sec_in);
    end
    step();
    n_checks++;
    if ({sec_load, min_load, hour_load} !== 3'b010 || min_in !== 6'd34) begin
      n_fail++; $display("FAIL load_min: got ld=%b%b%b min_in=%0d want 010/34", sec_load, min_load, hour_load, min_in);
    end
    step();
    n_checks++;
    if ({sec_load, min_load, hour_load} !== 3'b001 || hour_in !== 6'd12 || set_ack !== 1'b0) begin
      n_fail++; $display("FAIL load_hour: got ld=%b%b%b hour_in=%0d ack=%b want 001/12/0",
                         sec_load, min_load, hour_load, hour_in, set_ack);
    end
    step();
    n_checks++;
    if ({set_ack, set_err, running} !== 3'b101 || {sec_load, min_load, hour_load} !== 3'b000) begin
      n_fail++; $display("FAIL load_ack: got ack=%b err=%b run=%b want 1/0/1", set_ack, set_err, running);
    end
    set_req = 1'b0;
    step();
    n_checks++;
    if (set_ack !== 1'b0 || missed !== 4'd0 || running !== 1'b1) begin
      n_fail++; $display("FAIL load_post: got ack=%b missed=%0d run=%b want 0/0/1", set_ack, missed, running);
    end
  endtask

  task automatic test_reject();
    logic [17:0] vec [3];
    vec[0] = {6'd24, 6'd0,  6'd0};
    vec[1] = {6'd0,  6'd60, 6'd0};
    vec[2] = {6'd0,  6'd0,  6'd60};
    for (int k = 0; k < 3; k++) begin
      set_req = 1'b1; {set_hour, set_min, set_sec} = vec[k];
      step();
      n_checks++;
      if (running !== 1'b0 || {sec_load, min_load, hour_load} !== 3'b000) begin
        n_fail++; $display("FAIL rej%0d_check: got run=%b ld=%b%b%b want 0/000", k, running, sec_load, min_load, hour_load);
      end
      step();
      n_checks++;
      if ({set_ack, set_err, running} !== 3'b111 || {sec_load, min_load, hour_load} !== 3'b000) begin
        n_fail++; $display("FAIL rej%0d_ack: got ack=%b err=%b run=%b ld=%b%b%b want 1/1/1/000",
                           k, set_ack, set_err, running, sec_load, min_load, hour_load);
      end
      set_req = 1'b0;
      step();
      n_checks++;
      if (set_ack !== 1'b0 || running !== 1'b1) begin
        n_fail++; $display("FAIL rej%0d_post: got ack=%b run=%b want 0/1", k, set_ack, running);
      end
    end
  endtask

  task automatic test_run_tick();
    logic [3:0] exp_m [4];
    exp_m[0] = 4'd0; exp_m[1] = 4'd1; exp_m[2] = 4'd2; exp_m[3] = 4'd3;
    tick_in = 1'b1; set_req = 1'b1; set_hour = 6'd0; set_min = 6'd0; set_sec = 6'd0;
    #1;
    n_checks++;
    if (cnt_en !== 1'b1) begin n_fail++; $display("FAIL tick_accept_cycle: got cnt_en=%b want 1", cnt_en); end
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (cnt_en !== 1'b0 || missed !== exp_m[c]) begin
        n_fail++; $display("FAIL tick_gate%0d: got cnt_en=%b missed=%0d want 0/%0d", c, cnt_en, missed, exp_m[c]);
      end
    end
    step();
    n_checks++;
    if (set_ack !== 1'b1 || missed !== 4'd4 || cnt_en !== 1'b1) begin
      n_fail++; $display("FAIL tick_ack: got ack=%b missed=%0d en=%b want 1/4/1", set_ack, missed, cnt_en);
    end
    set_req = 1'b0;
    step();
    n_checks++;
    if (missed !== 4'd0 || cnt_en !== 1'b1) begin
      n_fail++; $display("FAIL tick_clear: got missed=%0d en=%b want 0/1", missed, cnt_en);
    end
    tick_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_req = 1'b1; set_hour = 6'd23; set_min = 6'd59; set_sec = 6'd59;
    step(); step();
    n_checks++;
    if (sec_load !== 1'b1 || sec_in !== 6'd59) begin
      n_fail++; $display("FAIL b2b_sec: got ld=%b sec_in=%0d want 1/59", sec_load, sec_in);
    end
    step(); step();
    n_checks++;
    if (hour_load !== 1'b1 || hour_in !== 6'd23) begin
      n_fail++; $display("FAIL b2b_hour: got ld=%b hour_in=%0d want 1/23", hour_load, hour_in);
    end
    step();
    n_checks++;
    if ({set_ack, set_err} !== 2'b10) begin n_fail++; $display("FAIL b2b_ack1: got ack=%b err=%b want 1/0", set_ack, set_err); end
    step();
    n_checks++;
    if (set_ack !== 1'b0 || running !== 1'b1) begin
      n_fail++; $display("FAIL b2b_gap: got ack=%b run=%b want 0/1", set_ack, running);
    end
    step();
    n_checks++;
    if (running !== 1'b0 || dut.state !== CHECK) begin
      n_fail++; $display("FAIL b2b_recheck: got run=%b state=%0d want 0/CHECK", running, dut.state);
    end
    step();
    n_checks++;
    if (sec_load !== 1'b1) begin n_fail++; $display("FAIL b2b_sec2: got %b want 1", sec_load); end
    step(); step(); step();
    n_checks++;
    if ({set_ack, set_err, running} !== 3'b101) begin
      n_fail++; $display("FAIL b2b_ack2: got ack=%b err=%b run=%b want 1/0/1", set_ack, set_err, running);
    end
    set_req = 1'b0;
    step();
  endtask

  task automatic test_reset_midload();
    set_req = 1'b1; set_hour = 6'd1; set_min = 6'd2; set_sec = 6'd3;
    step(); step(); step();
    n_checks++;
    if (min_load !== 1'b1 || min_in !== 6'd2) begin
      n_fail++; $display("FAIL mid_ldmin: got ld=%b min_in=%0d want 1/2", min_load, min_in);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({set_ack, set_err, sec_load, min_load, hour_load, cnt_en, running, missed,
         sec_in, min_in, hour_in} !== 29'd0) begin
      n_fail++; $display("FAIL mid_async: got ld=%b%b%b run=%b min_in=%0d want all 0",
                         sec_load, min_load, hour_load, running, min_in);
    end
    set_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) rst = 1'b1;
      step();
      n_checks++;
      if ({sec_load, min_load, hour_load} !== 3'b000) begin
        n_fail++; $display("FAIL mid_nostrobe%0d: got ld=%b%b%b want 000", c, sec_load, min_load, hour_load);
      end
    end
    n_checks++;
    if (dut.state !== IDLE) begin n_fail++; $display("FAIL mid_rearm: got state=%0d want IDLE", dut.state); end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_load();
    test_reject();
    test_run_tick();
    test_back_to_back();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no completion want finish");
    $fatal(1);
  end

endmodule

// File: doc/clock_load_sched.md
CLOCK_LOAD_SCHED -- requirements
Module: clock_load_sched

Interface
REQ-001 The block SHALL have parameter HOUR_MAX, default 23, giving the largest legal hour value.
REQ-002 The block SHALL have parameter ARM_CYCLES, default 2, giving the wait after reset before the first load, while the counter FSMs arm.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port tick_in, input, 1 bit: one-cycle once-per-second pulse.
REQ-006 The block SHALL have port set_req, input, 1 bit: request to load a new time; held until set_ack.
REQ-007 The block SHALL have ports set_hour, set_min and set_sec, each input, 6 bits: requested time, sampled when the request is accepted.
REQ-008 The block SHALL have port set_ack, output, 1 bit: one-cycle pulse that completes a request.
REQ-009 The block SHALL have port set_err, output, 1 bit: valid with set_ack; 1 means the request was rejected as out of range.
REQ-010 The block SHALL have ports sec_in, min_in and hour_in, each output, 6 bits: load values to the counter FSMs.
REQ-011 The block SHALL have ports sec_load, min_load and hour_load, each output, 1 bit: one-cycle load strobes.
REQ-012 The block SHALL have port cnt_en, output, 1 bit: gated tick to the seconds counter.
REQ-013 The block SHALL have port running, output, 1 bit: high while in RUN.
REQ-014 The block SHALL have port missed, output, 4 bits: saturating count of ticks dropped while not in RUN.

Function
REQ-015 The states SHALL be ARM, IDLE, CHECK, LD_SEC, LD_MIN, LD_HOUR, RUN.
REQ-016 ARM SHALL last exactly ARM_CYCLES cycles after reset release, then go to IDLE; set_req is ignored in ARM.
REQ-017 In IDLE or RUN, set_req=1 SHALL capture set_hour, set_min and set_sec into holding registers and go to CHECK on the next edge.
REQ-018 CHECK SHALL last one cycle and reject the request when hour>HOUR_MAX, min>59 or sec>59.
REQ-019 On rejection the block SHALL pulse set_ack=1 with set_err=1 and return to the state it came from (IDLE or RUN); counter values are untouched.
REQ-020 On acceptance the block SHALL go to LD_SEC, then LD_MIN, then LD_HOUR, one cycle each.
REQ-021 In each LD state the block SHALL assert exactly one strobe (sec_load, min_load, hour_load respectively) with the matching *_in value held stable that cycle.
REQ-022 When leaving LD_HOUR the block SHALL pulse set_ack=1 with set_err=0, clear missed, and enter RUN.
REQ-023 Acceptance latency SHALL be: set_req seen at edge N, set_ack high during cycle N+5.
REQ-024 The block SHALL drive cnt_en = tick_in AND (state==RUN), combinationally.
REQ-025 The block SHALL never assert cnt_en in any cycle where a load strobe is high.
REQ-026 A tick_in during any state other than RUN or ARM SHALL increment missed, saturating at 15.
REQ-027 set_req in RUN SHALL stop counting starting with the CHECK cycle.
REQ-028 A tick_in coinciding with set_req acceptance in RUN SHALL still pass through cnt_en that cycle, since the state is still RUN.
REQ-029 set_req held high after set_ack SHALL start a new request, with its capture on the cycle following set_ack.
REQ-030 The *_in outputs SHALL show the holding registers at all times; they are meaningful only when qualified by a load strobe.

Reset
REQ-031 rst low SHALL immediately force state=ARM, set_ack=0, set_err=0, all load strobes=0, cnt_en=0, running=0, missed=0, and holding registers=0.
REQ-032 Reset mid-load SHALL abort the sequence with no further strobes; after release the block re-arms for ARM_CYCLES cycles.

Structure
REQ-033 The state encoding enum and the constants SEC_MAX=59 and MIN_MAX=59 SHALL live in a shared package, clock_pkg.
REQ-034 The range check SHALL be a sub-module, time_range_chk: combinational, with inputs hour, min and sec and output bad.

Verification
REQ-035 Reset release, no request -> cnt_en=0 for 2 cycles, then running=0 and state IDLE; missed counts ticks.
REQ-036 Request 12:34:56 from IDLE -> sec_load/56, min_load/34 and hour_load/12 on consecutive cycles; set_ack=1 and set_err=0 at cycle N+5; running=1.
REQ-037 Request hour=24 -> set_ack=1 with set_err=1; no load strobes; state unchanged.
REQ-038 In RUN, request 00:00:00 with tick_in every cycle -> cnt_en=0 throughout CHECK..LD_HOUR; missed=4 before clearing at set_ack.
REQ-039 Twenty ticks while IDLE -> missed saturates at 15.
REQ-040 Reset asserted during LD_MIN -> hour_load never pulses; all outputs go to 0 asynchronously.
